kronos_lsu_wb_bridge: RTL and testbench

KRONOS_LSU_WB_BRIDGE -- requirements
Module: kronos_lsu_wb_bridge

---
 rtl/kronos_lsu_wb_bridge.sv | 134 +++++++++++++
 tb/tb_kronos_lsu_wb_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_lsu_wb_bridge.sv
// Bridges single LSU load/store requests onto a classic Wishbone bus cycle.
// Latency: 2 cycles minimum (capture, BUS with same-cycle ack, RESP/ack), plus slave wait states.
// Backpressure: one request in flight; data_req is only sampled in IDLE, slave stalls extend BUS up to TIMEOUT cycles.
//
// Ports:
//   clk, rstz           clock and synchronous active-low reset
//   data_addr/wr_data   LSU request address and store data
//   data_mask/wr_en     LSU byte enables and store qualifier
//   data_req            LSU request, held high until data_ack
//   data_rd_data        registered load data, held until the next completion
//   data_ack            one-cycle completion pulse
//   bus_error           one-cycle pulse alongside data_ack on slave error or timeout
//   wb_*_o / wb_*_i     Wishbone master signals (adr, dat, sel, we, cyc, stb / dat, ack, err)

module kronos_lsu_wb_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rstz,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wr_data,
   input  logic [3:0]  data_mask,
   input  logic        data_wr_en,
   input  logic        data_req,
   output logic [31:0] data_rd_data,
   output logic        data_ack,
   output logic        bus_error,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Last BUS cycle index before the transfer is forcibly ended.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state_q;
   logic [15:0] cnt_q;
   logic        err_q;
   logic [31:0] adr_q;
   logic [31:0] dat_q;
   logic [3:0]  sel_q;
   logic        we_q;
   logic        cyc_q;
   logic        ack_q;
   logic [31:0] rd_q;

   logic        timeout_hit;

   assign timeout_hit = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rstz) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         ack_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (data_req) begin
                  adr_q   <= data_addr;
                  dat_q   <= data_wr_data;
                  sel_q   <= data_mask;
                  we_q    <= data_wr_en;
                  cyc_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= ST_BUS;
               end
            end

            ST_BUS: begin
               // Error and timeout share one exit; error outranks a simultaneous ack.
               if (wb_err_i || (!wb_ack_i && timeout_hit)) begin
                  rd_q    <= '0;
                  err_q   <= 1'b1;
                  cyc_q   <= 1'b0;
                  ack_q   <= 1'b1;
                  state_q <= ST_RESP;
               end else if (wb_ack_i) begin
                  rd_q    <= we_q ? 32'h0 : wb_dat_i;
                  cyc_q   <= 1'b0;
                  ack_q   <= 1'b1;
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end

            ST_RESP: begin
               // The error flag doubles as the registered bus_error pulse.
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               cyc_q   <= 1'b0;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign wb_adr_o     = adr_q;
   assign wb_dat_o     = dat_q;
   assign wb_sel_o     = sel_q;
   assign wb_we_o      = we_q;
   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = cyc_q;
   assign data_rd_data = rd_q;
   assign data_ack     = ack_q;
   assign bus_error    = err_q;

endmodule

// File: tb/tb_kronos_lsu_wb_bridge.sv
// Randomized and directed bench for kronos_lsu_wb_bridge with a transaction-level reference model.
module tb_kronos_lsu_wb_bridge;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rstz;
   logic [31:0] data_addr, data_wr_data;
   logic [3:0]  data_mask;
   logic        data_wr_en, data_req;
   logic [31:0] data_rd_data;
   logic        data_ack, bus_error;
   logic [31:0] wb_adr_o, wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i, wb_err_i;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] prev_rd;

   always #5 clk = ~clk;

   kronos_lsu_wb_bridge #(.TIMEOUT(TO)) dut (
      .clk(clk), .rstz(rstz),
      .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
      .data_wr_en(data_wr_en), .data_req(data_req),
      .data_rd_data(data_rd_data), .data_ack(data_ack), .bus_error(bus_error),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   // kind: 0 = ack, 1 = err, 2 = ack+err, 3 = slave never answers.
   // k: BUS-cycle index (0-based) at which the slave answers.
   task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mask,
                          input logic we, input int kind, input int k, input logic [31:0] rdat,
                          input string name);
      logic        timed_out, exp_err;
      logic [31:0] exp_rd;
      int          resp_at, n, bus_n;
      bit          done;
      // Reference model: outcome from response kind/time and the timeout rule.
      timed_out = (kind == 3) || (k >= TO);
      resp_at   = timed_out ? TO - 1 : k;
      exp_err   = timed_out || (kind != 0);
      exp_rd    = (exp_err || we) ? 32'h0 : rdat;

      @(posedge clk); #1;
      vectors++;
      if (data_ack !== 1'b0 || bus_error !== 1'b0 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || data_rd_data !== prev_rd) begin
         miscompares++;
         $display("FAIL %s idle: ack=%b err=%b cyc=%b stb=%b rd=%h, want 0 0 0 0 rd=%h",
                  name, data_ack, bus_error, wb_cyc_o, wb_stb_o, data_rd_data, prev_rd);
      end
      data_addr = addr; data_wr_data = wd; data_mask = mask; data_wr_en = we; data_req = 1'b1;
      n = 0; bus_n = 0; done = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
         wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
         if (wb_cyc_o === 1'b1) begin
            vectors++;
            if ({wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, data_rd_data} !== {1'b1, addr, wd, mask, we, prev_rd}) begin
               miscompares++;
               $display("FAIL %s bus_outputs: stb=%b adr=%h dat=%h sel=%h we=%b rd=%h, want 1 %h %h %h %b %h",
                        name, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, data_rd_data, addr, wd, mask, we, prev_rd);
            end
            if (bus_n == k && kind != 3) begin
               wb_ack_i = (kind == 0 || kind == 2);
               wb_err_i = (kind == 1 || kind == 2);
               wb_dat_i = rdat;
            end
            bus_n++;
         end
         if (data_ack === 1'b1) begin
            done = 1;
            data_req = 1'b0;
         end else begin
            vectors++;
            if (bus_error !== 1'b0) begin
               miscompares++;
               $display("FAIL %s stray_bus_error: got %b want 0", name, bus_error);
            end
         end
      end
      if (!done) begin
         vectors++; miscompares++;
         $display("FAIL %s no_ack: got none within %0d cycles, want ack at cycle %0d", name, n, resp_at + 2);
         data_req = 1'b0;
      end else begin
         vectors++;
         if (n !== resp_at + 2) begin
            miscompares++;
            $display("FAIL %s ack_cycle: got %0d want %0d", name, n, resp_at + 2);
         end
         vectors++;
         if (bus_n !== resp_at + 1) begin
            miscompares++;
            $display("FAIL %s burst_len: got %0d want %0d", name, bus_n, resp_at + 1);
         end
         vectors++;
         if (data_rd_data !== exp_rd) begin
            miscompares++;
            $display("FAIL %s rd_data: got %h want %h", name, data_rd_data, exp_rd);
         end
         vectors++;
         if (bus_error !== exp_err) begin
            miscompares++;
            $display("FAIL %s bus_error: got %b want %b", name, bus_error, exp_err);
         end
         vectors++;
         if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s cyc_at_ack: got cyc=%b stb=%b want 0 0", name, wb_cyc_o, wb_stb_o);
         end
      end
      prev_rd = exp_rd;
   endtask

   task automatic test_reset();
      rstz = 1'b0;
      data_req = 1'b1; data_addr = $urandom; data_wr_data = $urandom; data_mask = 4'hF; data_wr_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, data_rd_data, data_ack, bus_error} !== '0) begin
         miscompares++;
         $display("FAIL reset_values: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rd=%h ack=%b err=%b, want all 0",
                  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, data_rd_data, data_ack, bus_error);
      end
      data_req = 1'b0;
      rstz = 1'b1;
      prev_rd = 32'h0;
   endtask

   task automatic test_read_zero_wait();
      run_txn(32'h0000_1004, 32'hA5A5_0000, 4'b1111, 1'b0, 0, 0, 32'hDEAD_BEEF, "read_zero_wait");
   endtask

   task automatic test_write_wait();
      run_txn(32'h0000_0020, 32'h1234_5678, 4'b0011, 1'b1, 0, 3, 32'hFFFF_FFFF, "write_3ws");
   endtask

   task automatic test_error();
      run_txn(32'h0000_0040, 32'h0, 4'b1111, 1'b0, 2, 1, 32'hCAFE_F00D, "err_with_ack");
      run_txn(32'h0000_0044, 32'h0, 4'b0100, 1'b0, 1, 0, 32'h1111_2222, "err_only");
   endtask

   task automatic test_timeout();
      run_txn(32'h0000_0080, 32'h0, 4'b1111, 1'b0, 3, 0, 32'h0, "timeout");
   endtask

   task automatic test_back_to_back();
      run_txn(32'h0000_0100, 32'h0, 4'b1111, 1'b0, 0, 0, 32'h0BAD_F00D, "b2b_first");
      run_txn(32'h0000_0104, 32'h0, 4'b1111, 1'b0, 0, 1, 32'h600D_CAFE, "b2b_second");
   endtask

   task automatic test_reset_mid_bus();
      int seen, n;
      @(posedge clk); #1;
      data_addr = 32'h0000_0200; data_wr_data = 32'h5555_AAAA; data_mask = 4'b1010; data_wr_en = 1'b1; data_req = 1'b1;
      seen = 0; n = 0;
      while (seen < 2 && n < 20) begin
         @(posedge clk); #1;
         n++;
         wb_ack_i = 1'b0; wb_err_i = 1'b0;
         if (wb_cyc_o === 1'b1) seen++;
      end
      vectors++;
      if (seen != 2) begin
         miscompares++;
         $display("FAIL rst_mid_bus_enter: got %0d BUS cycles want 2", seen);
      end
      rstz = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, data_rd_data, data_ack, bus_error} !== '0) begin
         miscompares++;
         $display("FAIL rst_mid_bus_values: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rd=%h ack=%b err=%b, want all 0",
                  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, data_rd_data, data_ack, bus_error);
      end
      rstz = 1'b1;
      data_req = 1'b0;
      prev_rd = 32'h0;
      repeat (3) begin
         @(posedge clk); #1;
         vectors++;
         if (data_ack !== 1'b0 || wb_cyc_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_bus_no_ack: ack=%b cyc=%b want 0 0", data_ack, wb_cyc_o);
         end
      end
      run_txn(32'h0000_0204, 32'h0, 4'b1111, 1'b0, 0, 2, 32'h7777_8888, "after_reset");
   endtask

   task automatic test_random();
      logic [31:0] a, wd, rd;
      logic [3:0]  m;
      logic        we;
      int          kind, k;
      for (int i = 0; i < 40; i++) begin
         a  = $urandom; a[1:0] = 2'b00;
         wd = $urandom; rd = $urandom;
         m  = 4'($urandom);
         we = 1'($urandom);
         kind = $urandom_range(0, 9);
         kind = (kind < 6) ? 0 : kind - 6;
         k  = $urandom_range(0, 5);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         run_txn(a, wd, m, we, kind, k, rd, "random");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rstz = 1'b0; data_req = 1'b0; data_addr = '0; data_wr_data = '0; data_mask = '0; data_wr_en = 1'b0;
      wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; prev_rd = '0;
      test_reset();
      test_read_zero_wait();
      test_write_wait();
      test_error();
      test_timeout();
      test_back_to_back();
      test_reset_mid_bus();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
